snn_spike_classifier: RTL and testbench

- Synthesizable output-side collector for the RANC SNN grid; sits on the grid's packet_out/packet_out_valid stream.
- Per frame, accumulates output spike packets into an NUM_OUTPUT-bit spike bitmap and per-class spike counters.
- At frame end, runs a sequential argmax and presents the winning class with a valid/ready handshake.
- Generalises the fixed 250-output bitmap capture to parametrised output count, class count, counter width and tie/error reporting.

---
 rtl/snn_spike_classifier_if.sv | 29 ++
 rtl/snn_spike_classifier.sv | 149 ++++++++++++++
 tb/tb_snn_spike_classifier.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_spike_classifier_if.sv
// Stream and result handshake between the SNN grid output, the classifier
// and the downstream consumer of the per-frame class decision.
interface snn_spike_classifier_if #(
  parameter int IDX_W = 8,
  parameter int CNT_W = 8,
  parameter int CLS_W = 4
);
  logic             tick;
  logic [IDX_W-1:0] packet_out;
  logic             packet_out_valid;
  logic             frame_done;
  logic             result_ready;
  logic             result_valid;
  logic [CLS_W-1:0] result_class;
  logic [CNT_W-1:0] result_count;
  logic             result_tie;

  // Grid / consumer side: drives spikes and frame markers, accepts results.
  modport master (
    output tick, packet_out, packet_out_valid, frame_done, result_ready,
    input  result_valid, result_class, result_count, result_tie
  );

  // Classifier side.
  modport slave (
    input  tick, packet_out, packet_out_valid, frame_done, result_ready,
    output result_valid, result_class, result_count, result_tie
  );
endinterface

// File: rtl/snn_spike_classifier.sv
// Output-side collector for the SNN grid: builds a per-frame spike bitmap
// and saturating per-class spike counts, then scans the counts one class
// per cycle to find the winning class and reports it with valid/ready.
module snn_spike_classifier #(
  parameter int NUM_OUTPUT  = 250,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 8,
  parameter int CNT_W       = 8,
  parameter int CLS_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  snn_spike_classifier_if.slave bus,
  output logic [NUM_OUTPUT-1:0] spike_bitmap,
  output logic                  busy,
  output logic                  err_index,
  output logic                  err_drop
);

  typedef enum logic [1:0] {ACCUM, ARGMAX, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CLS_W-1:0] LAST_CLASS = CLS_W'(NUM_CLASSES - 1);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg  [NUM_CLASSES];
  logic [CNT_W-1:0]        cnt_next [NUM_CLASSES];
  logic [NUM_OUTPUT-1:0]   bitmap_reg, bitmap_next;
  logic [CLS_W-1:0]        scan_reg, scan_next;
  logic [CLS_W-1:0]        best_class_reg, best_class_next;
  logic [CNT_W-1:0]        best_count_reg, best_count_next;
  logic                    tie_reg, tie_next;
  logic                    err_index_reg, err_index_next;
  logic                    err_drop_reg, err_drop_next;

  logic                    accum;
  logic                    frame_clear;
  logic                    pkt_in_range;
  logic                    pkt_ok;
  logic [CLS_W-1:0]        pkt_class;
  logic [CNT_W-1:0]        cur_cnt;

  // Packet qualification: only counted while accumulating and in range.
  assign accum        = (state_reg == ACCUM);
  assign frame_clear  = accum && bus.tick;
  assign pkt_in_range = (32'(bus.packet_out) < NUM_OUTPUT);
  assign pkt_ok       = accum && bus.packet_out_valid && pkt_in_range;
  assign pkt_class    = CLS_W'(32'(bus.packet_out) % NUM_CLASSES);

  // Per-class counters: a tick clears first so a same-cycle packet lands
  // in the new frame; the increment stops at all-ones.
  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_cnt
    logic [CNT_W-1:0] base_cnt;
    logic             hit;
    assign base_cnt     = frame_clear ? '0 : cnt_reg[gi];
    assign hit          = pkt_ok && (pkt_class == CLS_W'(gi));
    assign cnt_next[gi] = (hit && (base_cnt != CNT_MAX)) ? base_cnt + 1'b1 : base_cnt;
  end

  // Bitmap bits are stored MSB-first: neuron idx lives at NUM_OUTPUT-1-idx.
  for (genvar gi = 0; gi < NUM_OUTPUT; gi++) begin : g_bitmap
    assign bitmap_next[NUM_OUTPUT-1-gi] =
        (pkt_ok && (bus.packet_out == IDX_W'(gi))) |
        (!frame_clear && bitmap_reg[NUM_OUTPUT-1-gi]);
  end

  // Sticky error flags; only reset clears them.
  assign err_index_next = err_index_reg | (accum && bus.packet_out_valid && !pkt_in_range);
  assign err_drop_next  = err_drop_reg  | (!accum && (bus.packet_out_valid || bus.tick));

  assign cur_cnt = cnt_reg[scan_reg];

  // Next-state and argmax scan: first class seeds the running max, later
  // classes replace it only when strictly greater, so ties keep the lower index.
  always_comb begin
    state_next      = state_reg;
    scan_next       = scan_reg;
    best_class_next = best_class_reg;
    best_count_next = best_count_reg;
    tie_next        = tie_reg;
    case (state_reg)
      ACCUM: begin
        if (bus.frame_done) begin
          state_next = ARGMAX;
          scan_next  = '0;
        end
      end
      ARGMAX: begin
        if (scan_reg == '0) begin
          best_class_next = '0;
          best_count_next = cur_cnt;
          tie_next        = 1'b0;
        end else if (cur_cnt > best_count_reg) begin
          best_class_next = scan_reg;
          best_count_next = cur_cnt;
          tie_next        = 1'b0;
        end else if (cur_cnt == best_count_reg) begin
          tie_next = 1'b1;
        end
        if (scan_reg == LAST_CLASS) begin
          state_next = DONE;
        end else begin
          scan_next = scan_reg + 1'b1;
        end
      end
      DONE: begin
        if (bus.result_ready) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // State, accumulator and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ACCUM;
      for (int i = 0; i < NUM_CLASSES; i++) cnt_reg[i] <= '0;
      bitmap_reg     <= '0;
      scan_reg       <= '0;
      best_class_reg <= '0;
      best_count_reg <= '0;
      tie_reg        <= 1'b0;
      err_index_reg  <= 1'b0;
      err_drop_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      for (int i = 0; i < NUM_CLASSES; i++) cnt_reg[i] <= cnt_next[i];
      bitmap_reg     <= bitmap_next;
      scan_reg       <= scan_next;
      best_class_reg <= best_class_next;
      best_count_reg <= best_count_next;
      tie_reg        <= tie_next;
      err_index_reg  <= err_index_next;
      err_drop_reg   <= err_drop_next;
    end
  end

  assign bus.result_valid = (state_reg == DONE);
  assign bus.result_class = best_class_reg;
  assign bus.result_count = best_count_reg;
  assign bus.result_tie   = tie_reg;
  assign spike_bitmap     = bitmap_reg;
  assign busy             = (state_reg != ACCUM);
  assign err_index        = err_index_reg;
  assign err_drop         = err_drop_reg;

endmodule

// File: tb/tb_snn_spike_classifier.sv
// Directed bench for snn_spike_classifier: bitmap/counter capture, argmax
// with ties and saturation, range errors, busy drops and async reset.
module tb_snn_spike_classifier;

  localparam int NUM_OUTPUT  = 250;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_W       = 8;
  localparam int CNT_W       = 8;
  localparam int CLS_W       = 4;

  logic                  clk;
  logic                  reset_n;
  logic [NUM_OUTPUT-1:0] spike_bitmap;
  logic                  busy;
  logic                  err_index;
  logic                  err_drop;
  logic [NUM_OUTPUT-1:0] eb;

  int n_cmp  = 0;
  int n_fail = 0;

  snn_spike_classifier_if #(.IDX_W(IDX_W), .CNT_W(CNT_W), .CLS_W(CLS_W)) bus ();

  snn_spike_classifier #(
    .NUM_OUTPUT(NUM_OUTPUT), .NUM_CLASSES(NUM_CLASSES),
    .IDX_W(IDX_W), .CNT_W(CNT_W), .CLS_W(CLS_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .spike_bitmap(spike_bitmap),
    .busy(busy),
    .err_index(err_index),
    .err_drop(err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pkt(input int idx);
    bus.packet_out       = IDX_W'(idx);
    bus.packet_out_valid = 1'b1;
    cyc();
    bus.packet_out_valid = 1'b0;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
  endtask

  // frame_done in cycle T; result_valid must stay low through T+10 and rise at T+11.
  task automatic run_frame(input string tag);
    bus.frame_done = 1'b1;
    cyc();
    bus.frame_done = 1'b0;
    for (int k = 1; k <= NUM_CLASSES; k++) begin
      chk({tag, "_valid_early"}, 256'(bus.result_valid), 256'(0));
      cyc();
    end
    chk({tag, "_valid"}, 256'(bus.result_valid), 256'(1));
  endtask

  task automatic accept();
    bus.result_ready = 1'b1;
    cyc();
    bus.result_ready = 1'b0;
  endtask

  initial begin
    reset_n              = 1'b0;
    bus.tick             = 1'b0;
    bus.packet_out       = '0;
    bus.packet_out_valid = 1'b0;
    bus.frame_done       = 1'b0;
    bus.result_ready     = 1'b0;
    repeat (3) cyc();

    // Reset state
    chk("rst_valid",  256'(bus.result_valid), 256'(0));
    chk("rst_class",  256'(bus.result_class), 256'(0));
    chk("rst_count",  256'(bus.result_count), 256'(0));
    chk("rst_tie",    256'(bus.result_tie),   256'(0));
    chk("rst_bitmap", 256'(spike_bitmap),     256'(0));
    chk("rst_busy",   256'(busy),             256'(0));
    chk("rst_erri",   256'(err_index),        256'(0));
    chk("rst_errd",   256'(err_drop),         256'(0));
    reset_n = 1'b1;
    cyc();

    // Frame 1: 3,13,23 -> class 3 x3, 5 -> class 5 x1
    do_tick();
    pkt(3);
    eb = '0; eb[246] = 1'b1;
    chk("f1_bitmap_first", 256'(spike_bitmap), 256'(eb));
    pkt(13);
    pkt(23);
    pkt(5);
    bus.result_ready = 1'b1;
    run_frame("f1");
    chk("f1_class", 256'(bus.result_class), 256'(3));
    chk("f1_count", 256'(bus.result_count), 256'(3));
    chk("f1_tie",   256'(bus.result_tie),   256'(0));
    eb = '0; eb[246] = 1'b1; eb[236] = 1'b1; eb[226] = 1'b1; eb[244] = 1'b1;
    chk("f1_bitmap", 256'(spike_bitmap), 256'(eb));
    cyc();
    bus.result_ready = 1'b0;
    chk("f1_valid_drop", 256'(bus.result_valid), 256'(0));
    chk("f1_busy_drop",  256'(busy),             256'(0));

    // Frame 2: idx 1, then idx 2 arriving with frame_done -> tie, class 1 wins
    do_tick();
    pkt(1);
    bus.packet_out       = IDX_W'(2);
    bus.packet_out_valid = 1'b1;
    bus.frame_done       = 1'b1;
    cyc();
    bus.packet_out_valid = 1'b0;
    bus.frame_done       = 1'b0;
    repeat (NUM_CLASSES) cyc();
    chk("f2_valid", 256'(bus.result_valid), 256'(1));
    chk("f2_class", 256'(bus.result_class), 256'(1));
    chk("f2_count", 256'(bus.result_count), 256'(1));
    chk("f2_tie",   256'(bus.result_tie),   256'(1));
    eb = '0; eb[248] = 1'b1; eb[247] = 1'b1;
    chk("f2_bitmap", 256'(spike_bitmap), 256'(eb));
    accept();

    // Frame 3: 900 packets on idx 0 -> counter saturates at 255
    do_tick();
    bus.packet_out       = IDX_W'(0);
    bus.packet_out_valid = 1'b1;
    repeat (900) cyc();
    bus.packet_out_valid = 1'b0;
    run_frame("f3");
    chk("f3_class", 256'(bus.result_class), 256'(0));
    chk("f3_count", 256'(bus.result_count), 256'(255));
    chk("f3_tie",   256'(bus.result_tie),   256'(0));
    eb = '0; eb[249] = 1'b1;
    chk("f3_bitmap", 256'(spike_bitmap), 256'(eb));
    accept();

    // Frame 4: out-of-range indices only
    do_tick();
    chk("f4_erri_before", 256'(err_index), 256'(0));
    pkt(250);
    chk("f4_erri_250", 256'(err_index), 256'(1));
    pkt(251);
    chk("f4_bitmap", 256'(spike_bitmap), 256'(0));
    run_frame("f4");
    chk("f4_class", 256'(bus.result_class), 256'(0));
    chk("f4_count", 256'(bus.result_count), 256'(0));
    chk("f4_tie",   256'(bus.result_tie),   256'(1));
    chk("f4_erri",  256'(err_index),        256'(1));
    chk("f4_errd",  256'(err_drop),         256'(0));
    accept();

    // Frame 5: hold off ready for 20 cycles while driving traffic into DONE
    do_tick();
    pkt(7);
    run_frame("f5");
    for (int k = 0; k < 20; k++) begin
      bus.packet_out       = IDX_W'(7);
      bus.packet_out_valid = (k < 5);
      bus.tick             = (k == 10);
      bus.frame_done       = (k == 15);
      cyc();
    end
    bus.packet_out_valid = 1'b0;
    bus.tick             = 1'b0;
    bus.frame_done       = 1'b0;
    chk("f5_valid_held", 256'(bus.result_valid), 256'(1));
    chk("f5_class",      256'(bus.result_class), 256'(7));
    chk("f5_count",      256'(bus.result_count), 256'(1));
    chk("f5_tie",        256'(bus.result_tie),   256'(0));
    chk("f5_errd",       256'(err_drop),         256'(1));
    chk("f5_busy",       256'(busy),             256'(1));
    eb = '0; eb[242] = 1'b1;
    chk("f5_bitmap", 256'(spike_bitmap), 256'(eb));
    accept();
    chk("f5_valid_drop", 256'(bus.result_valid), 256'(0));
    chk("f5_busy_drop",  256'(busy),             256'(0));

    // Frame 6: tick and idx 9 together -> old class 7 cleared, class 9 wins
    bus.tick             = 1'b1;
    bus.packet_out       = IDX_W'(9);
    bus.packet_out_valid = 1'b1;
    cyc();
    bus.tick             = 1'b0;
    bus.packet_out_valid = 1'b0;
    eb = '0; eb[240] = 1'b1;
    chk("f6_bitmap", 256'(spike_bitmap), 256'(eb));
    run_frame("f6");
    chk("f6_class", 256'(bus.result_class), 256'(9));
    chk("f6_count", 256'(bus.result_count), 256'(1));
    chk("f6_tie",   256'(bus.result_tie),   256'(0));
    accept();

    // Frame 7: async reset in the middle of the argmax scan
    do_tick();
    pkt(4);
    bus.frame_done = 1'b1;
    cyc();
    bus.frame_done = 1'b0;
    repeat (6) cyc();
    chk("f7_busy_scan",  256'(busy),             256'(1));
    chk("f7_count_scan", 256'(bus.result_count), 256'(1));
    chk("f7_class_scan", 256'(bus.result_class), 256'(4));
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy",   256'(busy),             256'(0));
    chk("arst_valid",  256'(bus.result_valid), 256'(0));
    chk("arst_class",  256'(bus.result_class), 256'(0));
    chk("arst_count",  256'(bus.result_count), 256'(0));
    chk("arst_bitmap", 256'(spike_bitmap),     256'(0));
    chk("arst_erri",   256'(err_index),        256'(0));
    chk("arst_errd",   256'(err_drop),         256'(0));
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("post_rst_busy", 256'(busy), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
